pipeline_ctrl: RTL and testbench

//  Consumer side of the hazard interface. Takes stall_fetch/stall_decode/flush_execute/taken_branch

---
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/pipeline_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard-to-pipeline control bundle: hazard/execute inputs, fetch PC,
// stage valid bits, pipeline-register strobes and performance counters.
interface pipeline_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             stall_fetch;
    logic             stall_decode;
    logic             flush_execute;
    logic             taken_branch;
    logic [XLEN-1:0]  branch_target;
    logic             dmem_busy;

    logic [XLEN-1:0]  pc_fetch;
    logic             en_if_id;
    logic             clr_if_id;
    logic             en_id_ex;
    logic             clr_id_ex;
    logic             en_ex_mem;
    logic             en_mem_wb;
    logic             valid_decode;
    logic             valid_execute;
    logic             valid_mem;
    logic             valid_wb;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    // Hazard unit / execute side: drives requests, observes control outputs.
    modport master (
        output stall_fetch, stall_decode, flush_execute, taken_branch,
               branch_target, dmem_busy,
        input  pc_fetch, en_if_id, clr_if_id, en_id_ex, clr_id_ex,
               en_ex_mem, en_mem_wb, valid_decode, valid_execute,
               valid_mem, valid_wb, stall_cnt, flush_cnt, retire_cnt
    );

    // Pipeline controller side.
    modport slave (
        input  stall_fetch, stall_decode, flush_execute, taken_branch,
               branch_target, dmem_busy,
        output pc_fetch, en_if_id, clr_if_id, en_id_ex, clr_id_ex,
               en_ex_mem, en_mem_wb, valid_decode, valid_execute,
               valid_mem, valid_wb, stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller for a 5-stage RV64 pipe: owns the fetch PC, stage valid
// bits, pipeline-register enable/clear strobes and saturating perf counters.
module pipeline_ctrl #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pipeline_ctrl_if.slave bus
);

    localparam logic [XLEN-1:0]  RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACT_NORMAL   = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_FREEZE   = 2'd3
    } action_t;

    logic [XLEN-1:0]  pc_q;
    logic             valid_decode_q;
    logic             valid_execute_q;
    logic             valid_mem_q;
    logic             valid_wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] retire_cnt_q;

    logic    frz;
    logic    redir;
    logic    stl;
    action_t act;

    logic en_if_id;
    logic clr_if_id;
    logic en_id_ex;
    logic clr_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // A taken branch only counts when execute actually holds an instruction;
    // flush_execute without a redirect degrades to a stall so decode survives.
    always_comb begin
        frz   = bus.dmem_busy;
        redir = bus.taken_branch & valid_execute_q;
        stl   = (bus.stall_fetch | bus.stall_decode | bus.flush_execute) & ~redir;

        act = ACT_NORMAL;
        if (frz)        act = ACT_FREEZE;
        else if (redir) act = ACT_REDIRECT;
        else if (stl)   act = ACT_STALL;
    end

    // Strobe contract: en_* loads the pipeline register on the same rising
    // edge; clr_* overrides the load with a bubble. Both are combinational.
    always_comb begin
        en_if_id  = 1'b1;
        clr_if_id = 1'b0;
        en_id_ex  = 1'b1;
        clr_id_ex = 1'b0;
        en_ex_mem = 1'b1;
        en_mem_wb = 1'b1;
        unique case (act)
            ACT_FREEZE: begin
                en_if_id  = 1'b0;
                en_id_ex  = 1'b0;
                en_ex_mem = 1'b0;
                en_mem_wb = 1'b0;
            end
            ACT_REDIRECT: begin
                clr_if_id = 1'b1;
                clr_id_ex = 1'b1;
            end
            ACT_STALL: begin
                en_if_id  = 1'b0;
                clr_id_ex = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC_AL;
            valid_decode_q  <= 1'b0;
            valid_execute_q <= 1'b0;
            valid_mem_q     <= 1'b0;
            valid_wb_q      <= 1'b0;
        end else begin
            unique case (act)
                ACT_FREEZE: ;
                ACT_REDIRECT: begin
                    pc_q            <= {bus.branch_target[XLEN-1:2], 2'b00};
                    valid_decode_q  <= 1'b0;
                    valid_execute_q <= 1'b0;
                    valid_mem_q     <= valid_execute_q;
                    valid_wb_q      <= valid_mem_q;
                end
                ACT_STALL: begin
                    valid_execute_q <= 1'b0;
                    valid_mem_q     <= valid_execute_q;
                    valid_wb_q      <= valid_mem_q;
                end
                default: begin
                    pc_q            <= pc_q + XLEN'(4);
                    valid_decode_q  <= 1'b1;
                    valid_execute_q <= valid_decode_q;
                    valid_mem_q     <= valid_execute_q;
                    valid_wb_q      <= valid_mem_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (act != ACT_FREEZE && valid_wb_q)
                retire_cnt_q <= sat_inc(retire_cnt_q);
            if (act == ACT_STALL)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (act == ACT_REDIRECT)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign bus.pc_fetch      = pc_q;
    assign bus.en_if_id      = en_if_id;
    assign bus.clr_if_id     = clr_if_id;
    assign bus.en_id_ex      = en_id_ex;
    assign bus.clr_id_ex     = clr_id_ex;
    assign bus.en_ex_mem     = en_ex_mem;
    assign bus.en_mem_wb     = en_mem_wb;
    assign bus.valid_decode  = valid_decode_q;
    assign bus.valid_execute = valid_execute_q;
    assign bus.valid_mem     = valid_mem_q;
    assign bus.valid_wb      = valid_wb_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
    assign bus.retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (32-bit counters at PC 0, and 4-bit
// counters near the top of the address space) checked against a stage-occupancy model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_sf, in_sd, in_fe, in_tb, in_busy;
  logic [63:0] in_tgt;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  pipeline_ctrl_if #(.XLEN(64), .CNT_W(32)) bus0 ();
  pipeline_ctrl_if #(.XLEN(64), .CNT_W(4))  bus1 ();

  assign bus0.stall_fetch   = in_sf;
  assign bus0.stall_decode  = in_sd;
  assign bus0.flush_execute = in_fe;
  assign bus0.taken_branch  = in_tb;
  assign bus0.branch_target = in_tgt;
  assign bus0.dmem_busy     = in_busy;
  assign bus1.stall_fetch   = in_sf;
  assign bus1.stall_decode  = in_sd;
  assign bus1.flush_execute = in_fe;
  assign bus1.taken_branch  = in_tb;
  assign bus1.branch_target = in_tgt;
  assign bus1.dmem_busy     = in_busy;

  pipeline_ctrl #(.XLEN(64), .RESET_PC(64'h0), .CNT_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  pipeline_ctrl #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF4), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // ---------------- model ----------------
  // occ[i][0..3] = decode, execute, mem, writeback occupancy
  logic [63:0] rst_pc [2];
  logic [31:0] sat    [2];
  logic [63:0] m_pc   [2];
  logic        occ    [2][4];
  logic [31:0] m_stall[2], m_flush[2], m_retire[2];

  initial begin
    rst_pc[0] = 64'h0;
    rst_pc[1] = 64'hFFFF_FFFF_FFFF_FFF4;
    sat[0]    = 32'hFFFF_FFFF;
    sat[1]    = 32'h0000_000F;
  end

  function automatic logic [31:0] bump(input logic [31:0] c, input logic [31:0] mx);
    return (c == mx) ? c : c + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pc[i] = rst_pc[i] & ~64'h3;
        for (int s = 0; s < 4; s++) occ[i][s] = 1'b0;
        m_stall[i] = 0; m_flush[i] = 0; m_retire[i] = 0;
      end
    end else if (!in_busy) begin
      for (int i = 0; i < 2; i++) begin
        logic redirect, stall;
        redirect = in_tb && occ[i][1];
        stall    = (in_sf || in_sd || in_fe) && !redirect;
        if (occ[i][3]) m_retire[i] = bump(m_retire[i], sat[i]);
        // everything from execute onward always moves one stage down
        occ[i][3] = occ[i][2];
        occ[i][2] = occ[i][1];
        if (redirect) begin
          m_pc[i] = in_tgt & ~64'h3;
          occ[i][1] = 1'b0;
          occ[i][0] = 1'b0;
          m_flush[i] = bump(m_flush[i], sat[i]);
        end else if (stall) begin
          occ[i][1] = 1'b0;
          m_stall[i] = bump(m_stall[i], sat[i]);
        end else begin
          m_pc[i] = m_pc[i] + 64'd4;
          occ[i][1] = occ[i][0];
          occ[i][0] = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i,
                          input logic [63:0] pc, input logic [3:0] vld,
                          input logic [5:0] strb,
                          input logic [31:0] sc, input logic [31:0] fc, input logic [31:0] rc);
    logic redirect, stall;
    logic [5:0] es;
    redirect = in_tb && occ[i][1];
    stall    = (in_sf || in_sd || in_fe) && !redirect;
    // {en_if_id, clr_if_id, en_id_ex, clr_id_ex, en_ex_mem, en_mem_wb}
    if (in_busy)       es = 6'b000000;
    else if (redirect) es = 6'b111111;
    else if (stall)    es = 6'b001111;
    else               es = 6'b101011;
    chk($sformatf("pc[%0d]", i), pc, m_pc[i]);
    chk($sformatf("valid[%0d]", i), 64'(vld),
        64'({occ[i][3], occ[i][2], occ[i][1], occ[i][0]}));
    chk($sformatf("strobes[%0d]", i), 64'(strb), 64'(es));
    chk($sformatf("stall_cnt[%0d]", i), 64'(sc), 64'(m_stall[i]));
    chk($sformatf("flush_cnt[%0d]", i), 64'(fc), 64'(m_flush[i]));
    chk($sformatf("retire_cnt[%0d]", i), 64'(rc), 64'(m_retire[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_inst(0, bus0.pc_fetch,
               {bus0.valid_wb, bus0.valid_mem, bus0.valid_execute, bus0.valid_decode},
               {bus0.en_if_id, bus0.clr_if_id, bus0.en_id_ex, bus0.clr_id_ex,
                bus0.en_ex_mem, bus0.en_mem_wb},
               bus0.stall_cnt, bus0.flush_cnt, bus0.retire_cnt);
      chk_inst(1, bus1.pc_fetch,
               {bus1.valid_wb, bus1.valid_mem, bus1.valid_execute, bus1.valid_decode},
               {bus1.en_if_id, bus1.clr_if_id, bus1.en_id_ex, bus1.clr_id_ex,
                bus1.en_ex_mem, bus1.en_mem_wb},
               32'(bus1.stall_cnt), 32'(bus1.flush_cnt), 32'(bus1.retire_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sf, input logic sd, input logic fe,
                       input logic tb, input logic [63:0] tgt, input logic busy);
    in_sf = sf; in_sd = sd; in_fe = fe; in_tb = tb; in_tgt = tgt; in_busy = busy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // directed mixed vectors {sf, sd, fe, tb, busy}
  logic [4:0] vec [10];
  initial begin
    vec[0] = 5'b00000; vec[1] = 5'b00100; vec[2] = 5'b00000; vec[3] = 5'b00000;
    vec[4] = 5'b00011; vec[5] = 5'b00010; vec[6] = 5'b10000; vec[7] = 5'b01010;
    vec[8] = 5'b00000; vec[9] = 5'b11110;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 64'h0, 0);
    #1 rst_n = 1'b0;
    #2;
    chk("reset_pc0", bus0.pc_fetch, 64'h0);
    chk("reset_pc1", bus1.pc_fetch, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("reset_valid0", 64'({bus0.valid_decode, bus0.valid_execute, bus0.valid_mem, bus0.valid_wb}), 64'h0);
    chk("reset_retire0", 64'(bus0.retire_cnt), 64'h0);
    chk_en = 1'b1;
    #9 rst_n = 1'b1;

    // fill: pc 4,8,...,0x18; instance 1 wraps to 0 on the third edge
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("fill_pc", bus0.pc_fetch, 64'(4 * k));
      if (k == 3) chk("wrap_pc1", bus1.pc_fetch, 64'h0);
    end
    chk("fill_valid", 64'({bus0.valid_decode, bus0.valid_execute, bus0.valid_mem, bus0.valid_wb}), 64'hF);
    chk("fill_retire6", 64'(bus0.retire_cnt), 64'd2);
    step();
    chk("fill_retire7", 64'(bus0.retire_cnt), 64'd3);
    chk("fill_pc7", bus0.pc_fetch, 64'h1C);

    // load-use stall for one cycle
    drive(1, 1, 1, 0, 64'h0, 0);
    #1;
    chk("stall_en_if_id", 64'(bus0.en_if_id), 64'd0);
    chk("stall_clr_id_ex", 64'(bus0.clr_id_ex), 64'd1);
    step();
    drive(0, 0, 0, 0, 64'h0, 0);
    chk("stall_pc", bus0.pc_fetch, 64'h1C);
    chk("stall_vex", 64'(bus0.valid_execute), 64'd0);
    chk("stall_cnt", 64'(bus0.stall_cnt), 64'd1);
    step();

    // redirect together with a stall: redirect wins
    drive(1, 1, 1, 1, 64'h1003, 0);
    #1;
    chk("redir_clr_if_id", 64'(bus0.clr_if_id), 64'd1);
    step();
    drive(0, 0, 0, 0, 64'h0, 0);
    chk("redir_pc", bus0.pc_fetch, 64'h1000);
    chk("redir_vdec_vex", 64'({bus0.valid_decode, bus0.valid_execute}), 64'd0);
    chk("redir_flush", 64'(bus0.flush_cnt), 64'd1);
    chk("redir_stall_hold", 64'(bus0.stall_cnt), 64'd1);

    // freeze with a pending redirect, then release
    step();
    step();
    drive(0, 0, 0, 1, 64'h2000, 1);
    #1;
    chk("frz_en_ex_mem", 64'(bus0.en_ex_mem), 64'd0);
    repeat (3) step();
    chk("frz_pc", bus0.pc_fetch, 64'h1008);
    chk("frz_flush", 64'(bus0.flush_cnt), 64'd1);
    chk("frz_retire", 64'(bus0.retire_cnt), 64'd7);
    drive(0, 0, 0, 1, 64'h2000, 0);
    step();
    drive(0, 0, 0, 0, 64'h0, 0);
    chk("unfrz_pc", bus0.pc_fetch, 64'h2000);
    chk("unfrz_flush", 64'(bus0.flush_cnt), 64'd2);

    // mixed directed vectors, checked by the model every cycle
    for (int v = 0; v < 10; v++) begin
      drive(vec[v][4], vec[v][3], vec[v][2], vec[v][1], 64'h4000 + 64'(v * 16 + 1), vec[v][0]);
      step();
    end
    drive(0, 0, 0, 0, 64'h0, 0);

    // long free run: 4-bit retire counter saturates
    repeat (20) step();
    chk("sat_retire1", 64'(bus1.retire_cnt), 64'hF);

    // asynchronous reset in the middle of a redirect cycle
    drive(0, 0, 0, 1, 64'h3000, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_pc0", bus0.pc_fetch, 64'h0);
    chk("areset_pc1", bus1.pc_fetch, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("areset_valid0", 64'({bus0.valid_decode, bus0.valid_execute, bus0.valid_mem, bus0.valid_wb}), 64'h0);
    chk("areset_cnts0", 64'({bus0.stall_cnt, bus0.flush_cnt}), 64'h0);
    chk("areset_retire1", 64'(bus1.retire_cnt), 64'h0);
    drive(0, 0, 0, 0, 64'h0, 0);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("post_reset_pc", bus0.pc_fetch, 64'hC);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
